sr04_dist_uart_sender: RTL and testbench
========================================

// Module: sr04_dist_uart_sender
// PURPOSE
//  Downstream stage of the SR04 distance controller. Captures the 12-bit distance (cm)
//  on each cal_done pulse and converts it to 4 ASCII decimal digits with a sequential
//  double-dabble. It then pushes a fixed text frame, one byte per push, into the UART TX
//  FIFO, using a push/full handshake.
//  Frame: d3 d2 d1 d0 ['c' 'm'] CR LF, e.g. "0123cm\r\n".
// PARAMETERS
//  SUFFIX_EN   1   1: frame includes "cm" (8 bytes); 0: digits + CR LF only (6 bytes)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  i_cal_done    in   1   1-cycle pulse: i_dist valid this cycle
//  i_dist        in   12  distance in cm, unsigned 0..4095
//  i_tx_full     in   1   TX FIFO full; push is forbidden while high
//  o_push        out  1   TX FIFO write strobe; one byte per high cycle
//  o_tx_data     out  8   byte written when o_push=1
//  o_busy        out  1   high from the capture cycle until frame complete
//  o_send_done   out  1   1-cycle pulse after the last byte is pushed
// BEHAVIOUR
//  Reset (async): state=IDLE; o_push=0, o_tx_data=8'h00, o_busy=0, o_send_done=0.
//   Distance latch, BCD register and byte index clear to 0.
//  FSM: IDLE -> CONV -> SEND -> DONE -> IDLE.
//  IDLE
//   - i_cal_done=1: latch i_dist, clear BCD and shift counter, go to CONV.
//   - o_busy becomes 1 on the next cycle.
//  CONV
//   - Exactly 12 cycles, one double-dabble step per cycle.
//   - Each step adds 3 to every BCD nibble >=5, then shifts {bcd,bin} left by 1.
//   - After step 12, go to SEND with byte index 0.
//  SEND
//   - o_push = !i_tx_full (combinational, only in SEND).
//   - o_tx_data = frame[idx], valid throughout SEND, including while stalled.
//   - idx advances only on cycles where o_push=1.
//   - Digit byte = 8'h30 + nibble, MSB digit first. Leading zeros are kept (always 4 digits).
//   - Suffix bytes 8'h63 'c', 8'h6D 'm' (SUFFIX_EN=1), then 8'h0D, 8'h0A.
//   - After the push of the last byte, go to DONE.
//  DONE
//   - o_send_done=1 for exactly 1 cycle; o_busy=0 from the following cycle; go to IDLE.
//  Latency, no backpressure (i_cal_done sampled at edge k):
//   - CONV covers cycles k+1..k+12.
//   - Pushes occur at k+13..k+20 (SUFFIX_EN=1).
//   - o_send_done is high at k+21.
//  Backpressure: i_tx_full may assert on any SEND cycle.
//   - No byte is skipped or duplicated; the frame resumes at the same idx when full drops.
//   - No timeout.
//  i_cal_done while o_busy=1 (CONV/SEND/DONE) is ignored.
//   - Latched value and frame are unaffected; the new sample is dropped, not queued.
//  i_cal_done in the same cycle as the return to IDLE (DONE cycle) is ignored.
//   - Only pulses seen in IDLE start a frame.
//  Reset mid-frame: outputs go to reset values immediately.
//   - The partial frame is abandoned; no o_send_done is issued.
//  Outside SEND: o_push=0, o_tx_data=8'h00.
// TESTING
//  - i_dist=123, full=0, pulse cal_done -> pushes 30 31 32 33 63 6D 0D 0A at k+13..k+20, done @k+21
//  - i_dist=0 -> 30 30 30 30 63 6D 0D 0A; i_dist=4095 -> 34 30 39 35 63 6D 0D 0A
//  - i_dist=2048, full high 5 cycles after 2nd byte -> o_push=0, data held 8'h30, exactly 8 pushes total
//  - cal_done with i_dist=999 during SEND of 123 -> frame stays "0123cm\r\n", no second frame
//  - SUFFIX_EN=0, i_dist=7 -> 30 30 30 37 0D 0A, done 1 cycle after 6th push
//  - assert rst during byte 3 of SEND -> push/busy/done drop to 0 at once; next cal_done gives a clean full frame

Source files
------------

// File: rtl/sr04_dist_uart_sender.sv
// Converts each captured SR04 distance (cm) to four ASCII decimal digits and
// streams the text frame "dddd[cm]\r\n" into a UART TX FIFO over push/full.
module sr04_dist_uart_sender #(
    parameter bit SUFFIX_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cal_done,
    input  logic [11:0] i_dist,
    input  logic        i_tx_full,
    output logic        o_push,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_send_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = SUFFIX_EN ? 3'd7 : 3'd5;

    state_t      state;
    state_t      state_nx;
    logic [11:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  step_q;
    logic [2:0]  idx_q;
    logic [15:0] bcd_adj;
    logic [27:0] dd_nx;
    logic [7:0]  frame_byte;

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_nx = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0: frame_byte = {4'h3, bcd_q[15:12]};
            3'd1: frame_byte = {4'h3, bcd_q[11:8]};
            3'd2: frame_byte = {4'h3, bcd_q[7:4]};
            3'd3: frame_byte = {4'h3, bcd_q[3:0]};
            3'd4: frame_byte = SUFFIX_EN ? 8'h63 : 8'h0D;
            3'd5: frame_byte = SUFFIX_EN ? 8'h6D : 8'h0A;
            3'd6: frame_byte = 8'h0D;
            3'd7: frame_byte = 8'h0A;
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nx    = state;
        o_push      = 1'b0;
        o_tx_data   = 8'h00;
        o_busy      = (state != IDLE);
        o_send_done = 1'b0;
        case (state)
            IDLE: if (i_cal_done) state_nx = CONV;
            CONV: if (step_q == 4'd11) state_nx = SEND;
            SEND: begin
                o_push    = !i_tx_full;
                o_tx_data = frame_byte;
                if (!i_tx_full && idx_q == LAST_IDX) state_nx = DONE;
            end
            DONE: begin
                o_send_done = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath; pulses outside IDLE never touch the latched sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= 12'd0;
            bcd_q  <= 16'd0;
            step_q <= 4'd0;
            idx_q  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cal_done) begin
                        bin_q  <= i_dist;
                        bcd_q  <= 16'd0;
                        step_q <= 4'd0;
                        idx_q  <= 3'd0;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= dd_nx;
                    step_q         <= step_q + 4'd1;
                    idx_q          <= 3'd0;
                end
                SEND: begin
                    if (o_push) idx_q <= idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr04_dist_uart_sender.sv
// Directed bench for sr04_dist_uart_sender: scoreboard queues per instance,
// negedge monitors pop and compare every pushed byte.
module tb_sr04_dist_uart_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        cal_a, cal_b;
    logic [11:0] dist_a, dist_b;
    logic        full_a, full_b;
    logic        push_a, push_b;
    logic [7:0]  data_a, data_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    sr04_dist_uart_sender #(.SUFFIX_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_cal_done(cal_a), .i_dist(dist_a), .i_tx_full(full_a),
        .o_push(push_a), .o_tx_data(data_a), .o_busy(busy_a), .o_send_done(done_a)
    );

    sr04_dist_uart_sender #(.SUFFIX_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_cal_done(cal_b), .i_dist(dist_b), .i_tx_full(full_b),
        .o_push(push_b), .o_tx_data(data_b), .o_busy(busy_b), .o_send_done(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] d);
        n_checks++;
        n_fail++;
        $display("FAIL %s: push of %0h with no byte expected", name, d);
    endtask

    // Monitors: every byte the FIFO accepts must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (push_a) begin
                if (exp_a.size() == 0) unexpected("a_push", data_a);
                else chk("a_byte", {24'd0, data_a}, {24'd0, exp_a.pop_front()});
            end
            if (done_a) chk("a_frame_complete", exp_a.size(), 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (push_b) begin
                if (exp_b.size() == 0) unexpected("b_push", data_b);
                else chk("b_byte", {24'd0, data_b}, {24'd0, exp_b.pop_front()});
            end
            if (done_b) chk("b_frame_complete", exp_b.size(), 0);
        end
    end

    task automatic expect_frame(input bit sel, input logic [63:0] f, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            if (sel) exp_b.push_back(f[8*i +: 8]);
            else     exp_a.push_back(f[8*i +: 8]);
        end
    endtask

    // Pulse cal_done at edge k, then walk cycles after k. n = edges since k.
    // stall_at/ignore_at/rst_at < 0 disable that disturbance.
    task automatic run_frame(input bit sel, input logic [11:0] d, input int exp_first,
                             input int exp_done, input int stall_at, input int ignore_at,
                             input int rst_at);
        int n;
        int first;
        bit found;
        n     = 0;
        first = -1;
        found = 1'b0;
        @(negedge clk);
        if (sel) begin dist_b = d; cal_b = 1'b1; end
        else     begin dist_a = d; cal_a = 1'b1; end
        @(posedge clk);
        #1;
        cal_a = 1'b0;
        cal_b = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (n == 0) begin
                chk("busy_after_capture", sel ? busy_b : busy_a, 1);
                chk("data_zero_in_conv", sel ? data_b : data_a, 0);
            end
            if (stall_at >= 0 && n >= stall_at && n < stall_at + 5) begin
                chk("stall_push_low", push_a, 0);
                chk("stall_data_held", data_a, 8'h30);
            end
            if ((sel ? push_b : push_a) && first < 0) first = n;
            if (sel ? done_b : done_a) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
                cal_a = 1'b0;
                if (n == stall_at) full_a = 1'b1;
                if (n == stall_at + 5) full_a = 1'b0;
                if (n == ignore_at) begin dist_a = 12'd999; cal_a = 1'b1; end
                if (n == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_push", push_a, 0);
                    chk("rst_busy", busy_a, 0);
                    chk("rst_done", done_a, 0);
                    chk("rst_data", data_a, 0);
                    repeat (2) @(negedge clk);
                    exp_a.delete();
                    exp_b.delete();
                    rst = 1'b0;
                    return;
                end
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no o_send_done within 200 cycles, expected at %0d", exp_done);
        end else begin
            chk("first_push_cycle", first, exp_first);
            chk("done_cycle", n, exp_done);
            @(posedge clk);
            @(negedge clk);
            chk("busy_low_after_done", sel ? busy_b : busy_a, 0);
            chk("done_one_cycle", sel ? done_b : done_a, 0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        cal_a  = 1'b0; cal_b  = 1'b0;
        dist_a = 12'd0; dist_b = 12'd0;
        full_a = 1'b0; full_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_push", push_a, 0);
        chk("reset_data", data_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_busy_b", busy_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        expect_frame(1'b0, 64'h30313233_636D0D0A, 8);
        run_frame(1'b0, 12'd123, 12, 20, -1, -1, -1);

        expect_frame(1'b0, 64'h30303030_636D0D0A, 8);
        run_frame(1'b0, 12'd0, 12, 20, -1, -1, -1);

        expect_frame(1'b0, 64'h34303935_636D0D0A, 8);
        run_frame(1'b0, 12'd4095, 12, 20, -1, -1, -1);

        // Full held for 5 edges while byte index 1 ('0') is presented.
        expect_frame(1'b0, 64'h32303438_636D0D0A, 8);
        run_frame(1'b0, 12'd2048, 12, 25, 13, -1, -1);

        // A second pulse during SEND must not disturb or requeue anything.
        expect_frame(1'b0, 64'h30313233_636D0D0A, 8);
        run_frame(1'b0, 12'd123, 12, 20, -1, 15, -1);
        repeat (30) @(negedge clk);
        chk("no_second_frame_busy", busy_a, 0);
        chk("no_second_frame_queue", exp_a.size(), 0);

        expect_frame(1'b1, 64'h0000_30303037_0D0A, 6);
        run_frame(1'b1, 12'd7, 12, 18, -1, -1, -1);

        // Reset while the third byte is presented, then a clean frame.
        expect_frame(1'b0, 64'h30313233_636D0D0A, 8);
        run_frame(1'b0, 12'd123, 12, 20, -1, -1, 14);
        repeat (3) @(negedge clk);
        chk("post_rst_idle_busy", busy_a, 0);
        expect_frame(1'b0, 64'h30343536_636D0D0A, 8);
        run_frame(1'b0, 12'd456, 12, 20, -1, -1, -1);

        repeat (5) @(negedge clk);
        chk("final_queue_a", exp_a.size(), 0);
        chk("final_queue_b", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
